// File: rtl/i2c_write_master.sv
// Bit-level I2C write engine: START, 27 slots (3 bytes + 3 ACKs), STOP on an open-drain bus.
// Optional macro I2C_ACK_ABORT_EN: a NACK ends the frame early and jumps straight to STOP.
module i2c_write_master #(
   parameter int CLK_DIV = 125
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] i2c_data,
   output logic        done,
   output logic        ack,
   output logic        busy,
   output logic        i2c_sclk,
   inout  wire         i2c_sdat
);

   localparam int CW = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [4:0] LAST_SLOT = 5'd26;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_BIT   = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_phase;
   logic [4:0]    r_slot;
   logic [23:0]   r_shift;
   logic          r_nack;
   logic          r_done;
   logic          r_ack;
   logic          r_busy;
   logic          r_scl;
   logic          r_sda_oe;

   logic [1:0]    w_state_nxt;
   logic [1:0]    w_phase_nxt;
   logic [4:0]    w_slot_nxt;
   logic [23:0]   w_shift_nxt;
   logic          w_nack_nxt;
   logic          w_tick;
   logic          w_accept;
   logic          w_finish;
   logic          w_sda_high;

   function automatic logic is_ack_slot(input logic [4:0] slot);
      return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
   endfunction

   // Bus levels for a given quarter, returned as {scl, sda_pull_low}.
   function automatic logic [1:0] bus_drive(input logic [1:0] st, input logic [1:0] ph,
                                            input logic ack_slot, input logic msb);
      logic [1:0] v;
      case (st)
         S_START: begin
            case (ph)
               2'd0:    v = 2'b10;
               2'd1:    v = 2'b11;
               2'd2:    v = 2'b11;
               default: v = 2'b01;
            endcase
         end
         S_BIT: begin
            v = {ph[1], (ack_slot ? 1'b0 : ~msb)};
         end
         S_STOP: begin
            case (ph)
               2'd0:    v = 2'b01;
               2'd1:    v = 2'b11;
               default: v = 2'b10;
            endcase
         end
         default: v = 2'b10;
      endcase
      return v;
   endfunction

   assign w_sda_high = i2c_sdat;
   assign w_tick     = (r_state != S_IDLE) && (r_cnt == CNT_MAX);
   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_finish   = (r_state == S_STOP) && w_tick && (r_phase == 2'd3);

   // Next-state, slot sequencing, shifting and ACK sampling.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_slot_nxt  = r_slot;
      w_shift_nxt = r_shift;
      w_nack_nxt  = r_nack;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_START;
               w_phase_nxt = 2'd0;
               w_slot_nxt  = 5'd0;
               w_shift_nxt = i2c_data;
               w_nack_nxt  = 1'b0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_phase_nxt = r_phase + 2'd1;
               if (r_phase == 2'd3) begin
                  w_state_nxt = S_BIT;
                  w_slot_nxt  = 5'd0;
               end else begin
                  w_state_nxt = S_START;
               end
            end else begin
               w_phase_nxt = r_phase;
            end
         end
         S_BIT: begin
            if (w_tick && (r_phase == 2'd3)) begin
               w_phase_nxt = 2'd0;
               if (is_ack_slot(r_slot)) begin
                  w_nack_nxt = r_nack | w_sda_high;
               end else begin
                  w_shift_nxt = {r_shift[22:0], 1'b0};
               end
`ifdef I2C_ACK_ABORT_EN
               if ((r_slot == LAST_SLOT) || (is_ack_slot(r_slot) && w_sda_high)) begin
`else
               if (r_slot == LAST_SLOT) begin
`endif
                  w_state_nxt = S_STOP;
                  w_slot_nxt  = 5'd0;
               end else begin
                  w_slot_nxt  = r_slot + 5'd1;
               end
            end else if (w_tick) begin
               w_phase_nxt = r_phase + 2'd1;
            end else begin
               w_phase_nxt = r_phase;
            end
         end
         S_STOP: begin
            if (w_tick) begin
               w_phase_nxt = r_phase + 2'd1;
               if (r_phase == 2'd3) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_STOP;
               end
            end else begin
               w_phase_nxt = r_phase;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 2'd0;
            w_slot_nxt  = 5'd0;
         end
      endcase
   end

   // State, quarter counter, handshake flags and registered bus levels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_phase  <= 2'd0;
         r_slot   <= 5'd0;
         r_shift  <= 24'd0;
         r_nack   <= 1'b0;
         r_done   <= 1'b1;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
         r_scl    <= 1'b1;
         r_sda_oe <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_slot  <= w_slot_nxt;
         r_shift <= w_shift_nxt;
         r_nack  <= w_nack_nxt;
         if ((r_state == S_IDLE) || w_tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         // Outputs are set for the quarter being entered, so they stay glitch-free within it.
         {r_scl, r_sda_oe} <= bus_drive(w_state_nxt, w_phase_nxt,
                                        is_ack_slot(w_slot_nxt), w_shift_nxt[23]);
         if (w_accept) begin
            r_done <= 1'b0;
            r_ack  <= 1'b0;
            r_busy <= 1'b1;
         end else if (w_finish) begin
            r_done <= 1'b1;
            r_ack  <= ~r_nack;
            r_busy <= 1'b0;
         end else begin
            r_done <= r_done;
            r_ack  <= r_ack;
            r_busy <= r_busy;
         end
      end
   end

   assign done     = r_done;
   assign ack      = r_ack;
   assign busy     = r_busy;
   assign i2c_sclk = r_scl;
   assign i2c_sdat = r_sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master with a sampling slave/bus monitor (CLK_DIV=4).
module tb_i2c_write_master;

   localparam int CLK_DIV = 4;
`ifdef I2C_ACK_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] i2c_data;
   logic        done;
   logic        ack;
   logic        busy;
   logic        sclk;
   wire         sdat;

   logic        slave_low = 1'b0;
   logic        mon_clr = 1'b0;
   int          nack_pulse = 0;

   int          checks = 0;
   int          errors = 0;

   // monitor state
   logic        prev_scl = 1'b1;
   logic        prev_sda = 1'b1;
   int          rise_cnt = 0;
   int          pulse_cnt = 0;
   int          start_cnt = 0;
   int          stop_cnt = 0;
   logic [23:0] bits = 24'd0;

   pullup (sdat);
   assign sdat = slave_low ? 1'b0 : 1'bz;

   i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .i2c_data (i2c_data),
      .done     (done),
      .ack      (ack),
      .busy     (busy),
      .i2c_sclk (sclk),
      .i2c_sdat (sdat)
   );

   always #5 clk = ~clk;

   // Sampled bus monitor and ACKing slave: acts half a cycle after each DUT edge.
   always @(negedge clk) begin
      logic cs;
      logic cd;
      cs = sclk;
      cd = sdat;
      if (mon_clr) begin
         rise_cnt = 0; pulse_cnt = 0; start_cnt = 0; stop_cnt = 0;
         bits = 24'd0; slave_low = 1'b0;
      end else begin
         if (prev_scl && cs && prev_sda && !cd) start_cnt++;
         if (prev_scl && cs && !prev_sda && cd) stop_cnt++;
         if (!prev_scl && cs) rise_cnt++;
         if (prev_scl && !cs && (rise_cnt > pulse_cnt)) begin
            pulse_cnt++;
            if ((pulse_cnt % 9) != 0) bits = {bits[22:0], prev_sda};
            slave_low = ((pulse_cnt == 8) || (pulse_cnt == 17) || (pulse_cnt == 26))
                        && ((pulse_cnt + 1) != nack_pulse);
         end
      end
      prev_scl = cs;
      prev_sda = cd;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
   endtask

   typedef struct {
      logic [23:0] data;
      int          nack_p;
      int          pulses_off;
      int          pulses_on;
      int          cyc_off;
      int          cyc_on;
      logic        exp_ack;
      logic        inject;
   } vec_t;

   task automatic run_xfer(input vec_t v);
      int   n;
      int   exp_pulses;
      int   exp_cyc;
      logic [23:0] exp_bits;
      exp_pulses = ABORT ? v.pulses_on : v.pulses_off;
      exp_cyc    = ABORT ? v.cyc_on : v.cyc_off;
      nack_pulse = v.nack_p;
      clear_mon();
      start = 1'b1;
      i2c_data = v.data;
      step();
      start = 1'b0;
      n = 1;
      chk("done_low_c1", {31'd0, done}, 32'd0);
      chk("busy_c1", {31'd0, busy}, 32'd1);
      step();
      n = 2;
      chk("done_low_c2", {31'd0, done}, 32'd0);
      while (!done && n < 1000) begin
         step();
         n++;
         if (v.inject && n == 50) begin
            start = 1'b1;
            i2c_data = 24'hFFFFFF;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      exp_bits = v.data >> (24 - 8 * (exp_pulses / 9));
      chk("cycles", n, exp_cyc);
      chk("ack", {31'd0, ack}, {31'd0, v.exp_ack});
      chk("busy_end", {31'd0, busy}, 32'd0);
      step();
      chk("pulses", pulse_cnt, exp_pulses);
      chk("bits", {8'd0, bits}, {8'd0, exp_bits});
      chk("start_cond", start_cnt, 1);
      chk("stop_cond", stop_cnt, 1);
      step();
      step();
      chk("done_hold", {31'd0, done}, 32'd1);
      chk("ack_hold", {31'd0, ack}, {31'd0, v.exp_ack});
   endtask

   vec_t vecs[5];

   initial begin
      int n;
      vecs[0] = '{24'h340C10, 0,  27, 27, 465, 465, 1'b1, 1'b0};
      vecs[1] = '{24'h340C10, 18, 27, 18, 465, 321, 1'b0, 1'b0};
      vecs[2] = '{24'hA55A00, 0,  27, 27, 465, 465, 1'b1, 1'b0};
      vecs[3] = '{24'hFF00FF, 9,  27, 9,  465, 177, 1'b0, 1'b0};
      vecs[4] = '{24'h340C10, 0,  27, 27, 465, 465, 1'b1, 1'b1};

      // reset held with start asserted
      reset = 1'b0;
      start = 1'b1;
      i2c_data = 24'h340C10;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      chk("rst_done", {31'd0, done}, 32'd1);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_sclk", {31'd0, sclk}, 32'd1);
      chk("rst_sdat", {31'd0, sdat}, 32'd1);
      start = 1'b0;
      step();
      reset = 1'b1;
      step();
      step();
      chk("idle_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

      // start raised so that it is sampled on the completion edge
      nack_pulse = 0;
      clear_mon();
      start = 1'b1;
      i2c_data = 24'h340C10;
      step();
      start = 1'b0;
      n = 1;
      while (n < 464) begin
         step();
         n++;
      end
      chk("pre_done", {31'd0, done}, 32'd0);
      start = 1'b1;
      step();
      chk("cmpl_done", {31'd0, done}, 32'd1);
      chk("cmpl_busy", {31'd0, busy}, 32'd0);
      start = 1'b0;
      step();
      chk("no_accept_done", {31'd0, done}, 32'd1);
      chk("no_accept_busy", {31'd0, busy}, 32'd0);

      // asynchronous reset mid-transfer
      clear_mon();
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      while (n < 200) begin
         step();
         n++;
      end
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_done", {31'd0, done}, 32'd1);
      chk("abort_ack", {31'd0, ack}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_sclk", {31'd0, sclk}, 32'd1);
      chk("abort_sdat", {31'd0, sdat}, 32'd1);
      step();
      step();
      reset = 1'b1;
      step();
      run_xfer(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Bit-level I2C write engine that sits directly downstream of the audio-codec register sequencer.
- Accepts one 24-bit frame per start pulse: slave address/RW byte, register byte, data byte. Sends it MSB first on an open-drain bus, with START and STOP conditions.
- Samples the three slave ACK slots and reports completion plus an aggregate ack to the sequencer.
- Write-only; no reads and no clock stretching.

Parameters:
- CLK_DIV, 125, clk cycles per quarter SCL period. 50 MHz clk gives 100 kHz SCL. Legal range is 2 or more.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  request pulse; sampled only in IDLE
- i2c_data  input  24  frame, [23:16] addr+RW, [15:8] register, [7:0] data
- done  output  1  high when idle; low from the cycle after an accepted start until completion
- ack  output  1  1 = all three ACK slots were low; valid while done=1
- busy  output  1  high while a transfer is in progress
- i2c_sclk  output  1  I2C clock, push-pull
- i2c_sdat  inout  1  I2C data, driven 0 or Z only, never driven 1

Behaviour:
- Reset (asynchronous, reset=0) forces these values immediately:
  - done=1, ack=0, busy=0
  - i2c_sclk=1, i2c_sdat released (Z)
  - state=IDLE, tick counter=0, bit counter=0
- Reset mid-transfer aborts with no STOP generated. This is acceptable; the sequencer restarts from index 0.
- Quarter tick: a counter 0..CLK_DIV-1 runs in every state except IDLE. A tick is one cycle at CLK_DIV-1, after which the counter wraps to 0. Phase (0..3) advances on each tick.
- Start acceptance:
  - In IDLE, start=1 at a rising edge latches i2c_data into a 24-bit shift register.
  - On that same edge: done<=0, ack<=0, busy<=1, state<=START.
  - start while busy is ignored; i2c_data changes after acceptance have no effect.
- Handshake latency: done falls on the first edge after start is sampled. A consumer that checks done two cycles after raising start always sees 0.
- START state (4 quarters):
  - q0: SCL=1, SDA released.
  - q1: SDA=0.
  - q2: SDA=0.
  - q3: SCL=0.
  - Then go to BIT with bit counter=0.
- BIT state: 27 slots, numbered 0..26. Slots 8, 17 and 26 are ACK slots; the others carry data MSB first.
- Each slot takes 4 quarters:
  - q0: SCL=0. Drive SDA for data slots (0 drives low, 1 releases); release SDA for ACK slots.
  - q1: SCL=0.
  - q2: SCL=1.
  - q3: SCL=1. ACK slots sample i2c_sdat at the end of q3; a high sample sets an internal nack flag.
  - After q3, SCL returns to 0 at the next q0.
- The shift register shifts left by one after each data slot.
- After slot 26, go to STOP.
- STOP state:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA released.
  - q3: idle hold.
  - Then go to IDLE with done<=1, busy<=0, ack<=~nack.
- Total transfer time: (4 + 27*4 + 4) * CLK_DIV cycles, i.e. 116*CLK_DIV, plus 1 acceptance cycle.
- ack and done remain stable in IDLE until the next accepted start.
- Simultaneous events: start on the same edge that completion returns to IDLE is not accepted. Acceptance requires state==IDLE before the edge.
- SDA changes only while SCL=0, except for the START and STOP edges.

Optional Feature:
- Macro: I2C_ACK_ABORT_EN.
- Defined: the first high sample in any ACK slot ends the transfer immediately. The block skips the remaining slots, enters STOP at the next q0, and completes with ack=0. Transfer time shrinks accordingly.
- Undefined: all 27 slots always run. nack is accumulated, and ack=0 is reported only at completion.

Test Plan:
- Reset held 0 for 5 cycles, with start=1 throughout:
  - done=1, ack=0, busy=0, i2c_sclk=1, sdat=Z.
  - No transfer begins until reset=1.
- CLK_DIV=4, i2c_data=24'h340C10, slave model ACKs all slots:
  - Bus decodes to bytes 34, 0C, 10.
  - done=0 from cycle 1 onward; done=1 and ack=1 after 465 cycles.
  - 27 SCL high pulses; STOP is observed.
- Same frame, slave NACKs the second ACK slot (slot 17):
  - Macro off: all 27 SCL pulses, then ack=0.
  - Macro on: STOP after the 18th SCL pulse, then ack=0.
- A second start pulse at cycle 50 of an active transfer, with i2c_data changed to 24'hFFFFFF:
  - Ignored; the original frame completes unchanged.
- reset driven to 0 at cycle 200 of a transfer:
  - Outputs are at reset values asynchronously, within the same cycle.
  - A new start afterwards completes a normal transfer.
- Checker on every SCL-high interval: SDA is stable, except for exactly one falling edge (START) and one rising edge (STOP) per transfer.
